control_unit: RTL and testbench
===============================

# control_unit

Control-unit end of the parallel bus-and-tag channel, for one device address. Answers selection on 'address out'/'select out' and accepts the command. Drives initial status, byte-by-byte data transfer in either direction via AXI-Stream, and ending status. Used as the far-end model for channel bring-up and as the basis of emulated devices.

## Interface
- CLOCKS_PER_100_NS, 5, clocks per 100 ns (50 MHz)
- DEVICE_ADDR, 8'h00, address this unit responds to
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- a_bus_out, a_bus_out_parity  in  8,1  bus out + odd parity
- a_operational_out, a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out, a_suppress_out  in  1 each  outbound tags
- a_bus_in, a_bus_in_parity  out  8,1  bus in + odd parity (parity always registered from a_bus_in)
- a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in  out  1 each  inbound tags
- cmd_tdata/cmd_tvalid  out  8/1  received command, 1-clock pulse
- busy  in  1  device busy; initial status becomes BUSY
- end_req  in  1  device requests ending status (CE|DE)
- send_tdata/send_tvalid/send_tready  in/in/out  8/1/1  bytes to channel (read commands)
- recv_tdata/recv_tvalid/recv_tready  out/out/in  8/1/1  bytes from channel (write commands)
- status  out  8  last status presented

## Operation
- Status byte constants: BUSY 8'h10, CE 8'h08, DE 8'h04, UC 8'h02.
- Write = command[0]=1. Read = command[0]=0 and command≠0. Command 8'h00 = test I/O.
- States and transitions:
  - IDLE: if a_operational_out, a_address_out and a_bus_out==DEVICE_ADDR, latch match → SEL_WAIT. Otherwise a_select_in follows a_select_out (registered, 1-clock delay).
  - SEL_WAIT: on a_select_out or a_hold_out, raise a_operational_in → ADDR_IN.
  - ADDR_IN: drive bus_in=DEVICE_ADDR and raise a_address_in. On a_command_out, latch a_bus_out to command, pulse cmd_tvalid, drop a_address_in → CMD_DROP.
  - CMD_DROP: wait !a_command_out. Set status = BUSY if busy, else 8'h00 → INIT_STATUS.
  - INIT_STATUS: bus_in=status; after CLOCKS_PER_100_NS raise a_status_in; on a_service_out drop it; wait !a_service_out. Then test I/O or status≠0 → ENDING_DROP (operational_in down → IDLE); else → XFER.
  - XFER: end_req has priority → END_STATUS. Read: on send_tvalid, drive byte, pulse send_tready, → SVC_DELAY. Write: → SVC_DELAY directly.
  - SVC_DELAY: wait CLOCKS_PER_100_NS → SVC.
  - SVC: raise a_service_in. On a_service_out (write: latch a_bus_out to recv_tdata, set recv_tvalid) drop a_service_in → SVC_DROP. On a_command_out (stop): drop a_service_in, → END_STATUS.
  - SVC_DROP: wait !a_service_out and (write) !recv_tvalid → XFER.
  - END_STATUS: status=CE|DE on bus_in; wait 100 ns; raise a_status_in. On a_service_out drop it, wait !a_service_out, drop a_operational_in → IDLE.
- recv_tvalid holds until recv_tready; data held stable while valid.
- a_request_in always 0.

## Timing
- All outputs registered. Reset values: every tag 0, a_bus_in 8'h00, parity 1, cmd_tvalid/send_tready/recv_tvalid 0, status 8'h00, state IDLE.
- Bus-in data stable ≥ CLOCKS_PER_100_NS clocks before status_in/service_in rises.
- Tag responses one clock after the qualifying inbound edge is sampled.
- !a_operational_out in any state: next edge all inbound tags and stream valids drop, state IDLE.
- reset_n low mid-operation: same as above, plus timer cleared.
- Simultaneous a_service_out and a_command_out in SVC: stop wins; byte not delivered.

## Configuration
- CU_PARITY_CHECK_EN defined: bad odd parity on a_bus_out at address match is ignored; at command or write data capture it forces UC into the following status and goes to END_STATUS.
- Undefined: a_bus_out_parity is ignored.

## Structure
- Shared package channel_pkg: state enumeration, status constants (BUSY/CE/DE/UC), odd-parity function.
- Single module; the 100 ns timer is an inline 8-bit counter cleared on state change. No sub-module.

## Test plan
- Address 8'h05, DEVICE_ADDR 8'h05, command 8'h00 → address_in with bus_in 8'h05, status 8'h00, back to IDLE, no data phase.
- Address 8'h06 with DEVICE_ADDR 8'h05 → select_in echoes select_out, operational_in stays 0.
- Write 8'h01, channel sends 8'hA5,8'h3C, end_req → recv bytes A5,3C in order; ending status 8'h0C.
- Read 8'h02, send stream 8'h11,8'h22; channel stops after first byte → bus_in 8'h11 at service_in; command_out response drops service_in; 8'h22 not consumed; status 8'h0C.
- busy=1 at selection → initial status 8'h10, operational_in drops, no cmd_tvalid data phase.
- Drop operational_out during SVC → all inbound tags 0 next clock, state IDLE.

Source files
------------

// File: rtl/channel_pkg.sv
// Shared definitions for the bus-and-tag channel: control-unit FSM states,
// status byte constants and the odd-parity helper.
package channel_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL_WAIT,
        ST_ADDR_IN,
        ST_CMD_DROP,
        ST_INIT_STATUS,
        ST_INIT_SVC_DROP,
        ST_ENDING_DROP,
        ST_XFER,
        ST_SVC_DELAY,
        ST_SVC,
        ST_SVC_DROP,
        ST_END_STATUS,
        ST_END_SVC_DROP
    } cu_state_t;

    localparam logic [7:0] STAT_BUSY = 8'h10;
    localparam logic [7:0] STAT_CE   = 8'h08;
    localparam logic [7:0] STAT_DE   = 8'h04;
    localparam logic [7:0] STAT_UC   = 8'h02;

    // Parity bit that makes the 9-bit group carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Control-unit end of the bus-and-tag channel for one device address.
// Handles selection, command capture, initial status, byte transfer over
// AXI-Stream in either direction, and ending status.
// Optional: define CU_PARITY_CHECK_EN to check odd parity on a_bus_out at
// command and write-data capture (error forces UC into ending status).
module control_unit
    import channel_pkg::*;
#(
    parameter int         CLOCKS_PER_100_NS = 5,
    parameter logic [7:0] DEVICE_ADDR       = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] a_bus_out,
    input  logic       a_bus_out_parity,
    input  logic       a_operational_out,
    input  logic       a_hold_out,
    input  logic       a_select_out,
    input  logic       a_address_out,
    input  logic       a_command_out,
    input  logic       a_service_out,
    input  logic       a_suppress_out,
    output logic [7:0] a_bus_in,
    output logic       a_bus_in_parity,
    output logic       a_operational_in,
    output logic       a_select_in,
    output logic       a_address_in,
    output logic       a_status_in,
    output logic       a_service_in,
    output logic       a_request_in,
    output logic [7:0] cmd_tdata,
    output logic       cmd_tvalid,
    input  logic       busy,
    input  logic       end_req,
    input  logic [7:0] send_tdata,
    input  logic       send_tvalid,
    output logic       send_tready,
    output logic [7:0] recv_tdata,
    output logic       recv_tvalid,
    input  logic       recv_tready,
    output logic [7:0] status
);

    localparam logic [7:0] TIMER_LAST = 8'(CLOCKS_PER_100_NS - 1);

    cu_state_t  state, state_nx;
    logic [7:0] timer;
    logic [7:0] command, command_nx;
    logic       uc, uc_nx;
    logic [7:0] bus_in_nx, cmd_tdata_nx, recv_tdata_nx, status_nx;
    logic       op_in_nx, sel_in_nx, addr_in_nx, stat_in_nx, svc_in_nx;
    logic       cmd_tvalid_nx, send_tready_nx, recv_tvalid_nx;
    logic       timer_done, is_write, par_err;
    logic [7:0] end_stat;
    logic       unused_in;

`ifdef CU_PARITY_CHECK_EN
    assign par_err   = (odd_parity(a_bus_out) != a_bus_out_parity);
    assign unused_in = a_suppress_out;
`else
    assign par_err   = 1'b0;
    assign unused_in = a_suppress_out ^ a_bus_out_parity;
`endif

    assign timer_done   = (timer >= TIMER_LAST);
    assign is_write     = command[0];
    assign end_stat     = STAT_CE | STAT_DE | (uc ? STAT_UC : 8'h00);
    assign a_request_in = 1'b0;

    // State register and 100 ns timer; the timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            timer <= 8'h00;
        end else begin
            state <= state_nx;
            if (state_nx != state)  timer <= 8'h00;
            else if (timer != 8'hFF) timer <= timer + 8'h01;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx       = state;
        bus_in_nx      = a_bus_in;
        op_in_nx       = a_operational_in;
        sel_in_nx      = 1'b0;
        addr_in_nx     = a_address_in;
        stat_in_nx     = a_status_in;
        svc_in_nx      = a_service_in;
        cmd_tdata_nx   = cmd_tdata;
        cmd_tvalid_nx  = 1'b0;
        send_tready_nx = 1'b0;
        recv_tdata_nx  = recv_tdata;
        recv_tvalid_nx = recv_tvalid;
        status_nx      = status;
        command_nx     = command;
        uc_nx          = uc;

        if (recv_tvalid && recv_tready) recv_tvalid_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                sel_in_nx = a_select_out;
                uc_nx     = 1'b0;
                if (a_operational_out && a_address_out && a_bus_out == DEVICE_ADDR)
                    state_nx = ST_SEL_WAIT;
            end
            ST_SEL_WAIT: if (a_select_out || a_hold_out) begin
                op_in_nx   = 1'b1;
                addr_in_nx = 1'b1;
                bus_in_nx  = DEVICE_ADDR;
                state_nx   = ST_ADDR_IN;
            end
            ST_ADDR_IN: if (a_command_out) begin
                command_nx    = a_bus_out;
                cmd_tdata_nx  = a_bus_out;
                cmd_tvalid_nx = 1'b1;
                addr_in_nx    = 1'b0;
                uc_nx         = par_err;
                state_nx      = ST_CMD_DROP;
            end
            ST_CMD_DROP: if (!a_command_out) begin
                if (uc) begin
                    status_nx = end_stat;
                    bus_in_nx = end_stat;
                    state_nx  = ST_END_STATUS;
                end else begin
                    status_nx = busy ? STAT_BUSY : 8'h00;
                    bus_in_nx = busy ? STAT_BUSY : 8'h00;
                    state_nx  = ST_INIT_STATUS;
                end
            end
            ST_INIT_STATUS: begin
                if (a_status_in && a_service_out) begin
                    stat_in_nx = 1'b0;
                    state_nx   = ST_INIT_SVC_DROP;
                end else if (!a_status_in && timer_done) begin
                    stat_in_nx = 1'b1;
                end
            end
            ST_INIT_SVC_DROP: if (!a_service_out) begin
                // Test I/O and any non-zero initial status end the connection here.
                state_nx = (command == 8'h00 || status != 8'h00) ? ST_ENDING_DROP : ST_XFER;
            end
            ST_ENDING_DROP: begin
                op_in_nx = 1'b0;
                state_nx = ST_IDLE;
            end
            ST_XFER: begin
                if (end_req) begin
                    status_nx = end_stat;
                    bus_in_nx = end_stat;
                    state_nx  = ST_END_STATUS;
                end else if (is_write) begin
                    state_nx = ST_SVC_DELAY;
                end else if (send_tvalid) begin
                    bus_in_nx      = send_tdata;
                    send_tready_nx = 1'b1;
                    state_nx       = ST_SVC_DELAY;
                end
            end
            ST_SVC_DELAY: if (timer_done) begin
                svc_in_nx = 1'b1;
                state_nx  = ST_SVC;
            end
            ST_SVC: begin
                // A stop (command_out) beats a simultaneous service_out.
                if (a_command_out) begin
                    svc_in_nx = 1'b0;
                    status_nx = end_stat;
                    bus_in_nx = end_stat;
                    state_nx  = ST_END_STATUS;
                end else if (a_service_out) begin
                    svc_in_nx = 1'b0;
                    state_nx  = ST_SVC_DROP;
                    if (is_write) begin
                        if (par_err) begin
                            uc_nx = 1'b1;
                        end else begin
                            recv_tdata_nx  = a_bus_out;
                            recv_tvalid_nx = 1'b1;
                        end
                    end
                end
            end
            ST_SVC_DROP: if (!a_service_out && !recv_tvalid) begin
                if (uc) begin
                    status_nx = end_stat;
                    bus_in_nx = end_stat;
                    state_nx  = ST_END_STATUS;
                end else begin
                    state_nx = ST_XFER;
                end
            end
            ST_END_STATUS: begin
                if (a_status_in && a_service_out) begin
                    stat_in_nx = 1'b0;
                    state_nx   = ST_END_SVC_DROP;
                end else if (!a_status_in && timer_done) begin
                    stat_in_nx = 1'b1;
                end
            end
            ST_END_SVC_DROP: if (!a_service_out) begin
                op_in_nx = 1'b0;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // Loss of operational_out aborts everything on the next edge.
        if (!a_operational_out) begin
            state_nx       = ST_IDLE;
            op_in_nx       = 1'b0;
            sel_in_nx      = 1'b0;
            addr_in_nx     = 1'b0;
            stat_in_nx     = 1'b0;
            svc_in_nx      = 1'b0;
            cmd_tvalid_nx  = 1'b0;
            send_tready_nx = 1'b0;
            recv_tvalid_nx = 1'b0;
            uc_nx          = 1'b0;
        end
    end

    // Output and datapath registers; bus-in parity always tracks bus-in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_bus_in         <= 8'h00;
            a_bus_in_parity  <= 1'b1;
            a_operational_in <= 1'b0;
            a_select_in      <= 1'b0;
            a_address_in     <= 1'b0;
            a_status_in      <= 1'b0;
            a_service_in     <= 1'b0;
            cmd_tdata        <= 8'h00;
            cmd_tvalid       <= 1'b0;
            send_tready      <= 1'b0;
            recv_tdata       <= 8'h00;
            recv_tvalid      <= 1'b0;
            status           <= 8'h00;
            command          <= 8'h00;
            uc               <= 1'b0;
        end else begin
            a_bus_in         <= bus_in_nx;
            a_bus_in_parity  <= odd_parity(bus_in_nx);
            a_operational_in <= op_in_nx;
            a_select_in      <= sel_in_nx;
            a_address_in     <= addr_in_nx;
            a_status_in      <= stat_in_nx;
            a_service_in     <= svc_in_nx;
            cmd_tdata        <= cmd_tdata_nx;
            cmd_tvalid       <= cmd_tvalid_nx;
            send_tready      <= send_tready_nx;
            recv_tdata       <= recv_tdata_nx;
            recv_tvalid      <= recv_tvalid_nx;
            status           <= status_nx;
            command          <= command_nx;
            uc               <= uc_nx;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Channel-side bench for control_unit: scripted tag sequences, with a
// negedge monitor that checks bus-in, commands and received bytes against
// expectation queues filled as stimulus is driven.
module tb_control_unit;
    import channel_pkg::*;

    localparam logic [7:0] DEV = 8'h05;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bus_out = 8'h00;
    logic       bus_par = 1'b1;
    logic       op_out = 1'b0, hold_out = 1'b0, select_out = 1'b0, address_out = 1'b0;
    logic       command_out = 1'b0, service_out = 1'b0, suppress_out = 1'b0;
    logic [7:0] bus_in;
    logic       bus_in_par, op_in, select_in, address_in, status_in, service_in, request_in;
    logic [7:0] cmd_tdata;
    logic       cmd_tvalid;
    logic       busy = 1'b0, end_req = 1'b0;
    logic [7:0] send_tdata = 8'h00;
    logic       send_tvalid = 1'b0;
    logic       send_tready;
    logic [7:0] recv_tdata;
    logic       recv_tvalid;
    logic       recv_tready = 1'b1;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;
    int n_send = 0;
    int exp_bus[$];
    logic [7:0] exp_cmd[$];
    logic [7:0] exp_recv[$];
    logic prev_addr = 1'b0, prev_stat = 1'b0, prev_svc = 1'b0;

    control_unit #(.CLOCKS_PER_100_NS(5), .DEVICE_ADDR(DEV)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_bus_out(bus_out), .a_bus_out_parity(bus_par),
        .a_operational_out(op_out), .a_hold_out(hold_out), .a_select_out(select_out),
        .a_address_out(address_out), .a_command_out(command_out),
        .a_service_out(service_out), .a_suppress_out(suppress_out),
        .a_bus_in(bus_in), .a_bus_in_parity(bus_in_par),
        .a_operational_in(op_in), .a_select_in(select_in), .a_address_in(address_in),
        .a_status_in(status_in), .a_service_in(service_in), .a_request_in(request_in),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
        .busy(busy), .end_req(end_req),
        .send_tdata(send_tdata), .send_tvalid(send_tvalid), .send_tready(send_tready),
        .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid), .recv_tready(recv_tready),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tag_val(input int idx);
        case (idx)
            0:       return op_in;
            1:       return select_in;
            2:       return address_in;
            3:       return status_in;
            4:       return service_in;
            default: return send_tready;
        endcase
    endfunction

    // Bounded wait on a DUT output; an expired bound shows up as a failed check.
    task automatic wait_tag(input int idx, input logic val, input string tag);
        int n = 0;
        while (tag_val(idx) !== val && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tag_val(idx)), 32'(val));
    endtask

    // Scoreboard monitor: bus-in at every address/status/service rise,
    // command pulses, received bytes and send-stream handshakes.
    always @(negedge clk) begin
        if ((address_in && !prev_addr) || (status_in && !prev_stat) || (service_in && !prev_svc)) begin
            if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
            else begin
                int e;
                e = exp_bus.pop_front();
                if (e >= 0) begin
                    chk("bus_in", 32'(bus_in), 32'(e));
                    chk("bus_in_parity", 32'(bus_in_par), 32'(~^bus_in));
                end
            end
        end
        if (cmd_tvalid) begin
            if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
            else chk("cmd_tdata", 32'(cmd_tdata), 32'(exp_cmd.pop_front()));
        end
        if (recv_tvalid && recv_tready) begin
            if (exp_recv.size() == 0) chk("recv_unexpected", 32'(recv_tdata), 32'hFFFF);
            else chk("recv_tdata", 32'(recv_tdata), 32'(exp_recv.pop_front()));
        end
        if (send_tvalid && send_tready) n_send++;
        prev_addr = address_in;
        prev_stat = status_in;
        prev_svc  = service_in;
    end

    task automatic select_dev(input logic [7:0] a);
        bus_out = a; bus_par = odd_parity(a); address_out = 1'b1;
        @(negedge clk);
        select_out = 1'b1;
        wait_tag(0, 1'b1, "op_in_up");
        wait_tag(2, 1'b1, "addr_in_up");
        address_out = 1'b0; select_out = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bus_out = c; bus_par = odd_parity(c); command_out = 1'b1;
        wait_tag(2, 1'b0, "addr_in_drop");
        command_out = 1'b0;
    endtask

    task automatic status_cycle(input string tag);
        wait_tag(3, 1'b1, {tag, "_status_up"});
        service_out = 1'b1;
        wait_tag(3, 1'b0, {tag, "_status_drop"});
        service_out = 1'b0;
    endtask

    task automatic end_conn(input logic [7:0] st, input string tag);
        wait_tag(0, 1'b0, {tag, "_op_in_drop"});
        chk({tag, "_status"}, 32'(status), 32'(st));
    endtask

    task automatic write_byte(input logic [7:0] b, input logic last);
        wait_tag(4, 1'b1, "wr_svc_up");
        exp_recv.push_back(b);
        bus_out = b; bus_par = odd_parity(b); service_out = 1'b1;
        if (last) end_req = 1'b1;
        wait_tag(4, 1'b0, "wr_svc_drop");
        service_out = 1'b0;
    endtask

    task automatic test_io(input string tag);
        exp_bus.push_back(DEV); exp_bus.push_back(8'h00);
        exp_cmd.push_back(8'h00);
        select_dev(DEV);
        send_cmd(8'h00);
        status_cycle(tag);
        end_conn(8'h00, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_in", 32'(op_in), 0);
        chk("rst_tags", 32'({select_in, address_in, status_in, service_in, request_in}), 0);
        chk("rst_bus_in", 32'(bus_in), 0);
        chk("rst_parity", 32'(bus_in_par), 1);
        chk("rst_valids", 32'({cmd_tvalid, send_tready, recv_tvalid}), 0);
        chk("rst_status", 32'(status), 0);
        reset_n = 1'b1;
        op_out = 1'b1;
        repeat (2) @(negedge clk);

        // Test I/O: address, zero status, no data phase.
        test_io("tio");

        // Foreign address: select passes through, no connection.
        bus_out = 8'h06; bus_par = odd_parity(8'h06); address_out = 1'b1;
        @(negedge clk);
        select_out = 1'b1;
        repeat (2) @(negedge clk);
        chk("pass_sel_in", 32'(select_in), 1);
        chk("pass_op_in", 32'(op_in), 0);
        select_out = 1'b0;
        repeat (2) @(negedge clk);
        chk("pass_sel_drop", 32'(select_in), 0);
        address_out = 1'b0;
        @(negedge clk);

        // Write: two bytes then ending status.
        exp_bus.push_back(DEV); exp_bus.push_back(8'h00);
        exp_bus.push_back(-1); exp_bus.push_back(-1); exp_bus.push_back(8'h0C);
        exp_cmd.push_back(8'h01);
        select_dev(DEV);
        send_cmd(8'h01);
        status_cycle("wr");
        write_byte(8'hA5, 1'b0);
        write_byte(8'h3C, 1'b1);
        status_cycle("wr_end");
        end_req = 1'b0;
        end_conn(8'h0C, "wr");

        // Read: channel stops on the first byte; second byte stays queued.
        send_tdata = 8'h11; send_tvalid = 1'b1;
        exp_bus.push_back(DEV); exp_bus.push_back(8'h00);
        exp_bus.push_back(8'h11); exp_bus.push_back(8'h0C);
        exp_cmd.push_back(8'h02);
        select_dev(DEV);
        send_cmd(8'h02);
        status_cycle("rd");
        wait_tag(5, 1'b1, "rd_send_tready");
        @(negedge clk);
        send_tdata = 8'h22;
        wait_tag(4, 1'b1, "rd_svc_up");
        command_out = 1'b1;
        wait_tag(4, 1'b0, "rd_stop_svc_drop");
        command_out = 1'b0;
        status_cycle("rd_end");
        end_conn(8'h0C, "rd");
        chk("rd_send_count", 32'(n_send), 1);
        send_tvalid = 1'b0;

        // Write where service_out and command_out coincide: stop wins.
        exp_bus.push_back(DEV); exp_bus.push_back(8'h00);
        exp_bus.push_back(-1); exp_bus.push_back(8'h0C);
        exp_cmd.push_back(8'h01);
        select_dev(DEV);
        send_cmd(8'h01);
        status_cycle("sim");
        wait_tag(4, 1'b1, "sim_svc_up");
        bus_out = 8'h77; bus_par = odd_parity(8'h77);
        service_out = 1'b1; command_out = 1'b1;
        wait_tag(4, 1'b0, "sim_svc_drop");
        service_out = 1'b0; command_out = 1'b0;
        status_cycle("sim_end");
        end_conn(8'h0C, "sim");

        // Busy device: initial status BUSY ends the connection.
        busy = 1'b1;
        exp_bus.push_back(DEV); exp_bus.push_back(STAT_BUSY);
        exp_cmd.push_back(8'h03);
        select_dev(DEV);
        send_cmd(8'h03);
        status_cycle("busy");
        end_conn(STAT_BUSY, "busy");
        busy = 1'b0;

        // Operational_out dropped during service.
        exp_bus.push_back(DEV); exp_bus.push_back(8'h00); exp_bus.push_back(-1);
        exp_cmd.push_back(8'h01);
        select_dev(DEV);
        send_cmd(8'h01);
        status_cycle("drop");
        wait_tag(4, 1'b1, "drop_svc_up");
        op_out = 1'b0;
        @(negedge clk);
        chk("drop_tags", 32'({op_in, select_in, address_in, status_in, service_in}), 0);
        chk("drop_valids", 32'({cmd_tvalid, send_tready, recv_tvalid}), 0);
        op_out = 1'b1;
        @(negedge clk);
        test_io("after_drop");

        repeat (3) @(negedge clk);
        chk("exp_bus_left", 32'(exp_bus.size()), 0);
        chk("exp_cmd_left", 32'(exp_cmd.size()), 0);
        chk("exp_recv_left", 32'(exp_recv.size()), 0);
        chk("send_total", 32'(n_send), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
